dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory request/response interface.
- Accepts one load/store request at a time and applies byte-lane write masks to a word-organised RAM. Returns read data and an error flag after a configurable number of wait states.
- Sits between the pipeline's memory stage and the data RAM, so the core can run against slow or out-of-range memory under a handshake instead of a fixed single-cycle array.

Parameters:
- DEPTH, 64, number of 32-bit words in the RAM; must be a power of two, at least 2.
- WAIT, 0, extra wait-state cycles between request accept and response; range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address; bits [1:0] ignored, lanes come from req_wmask.
- req_wdata  input  32  store data, already lane-aligned by the core.
- req_wmask  input  4  byte-lane write enables; 4'b0000 means load.
- resp_valid  output  1  response present.
- resp_ready  input  1  core accepts the response.
- resp_rdata  output  32  word read at the request address, value before any write.
- resp_err  output  1  request address was out of range.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (resetn).
- Reset drives: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. RAM contents are not reset.
- States:
  - IDLE: req_ready=1.
  - WAITS: req_ready=0; counter runs.
  - RESP: req_ready=0; resp_valid=1.
- Accept: req_valid & req_ready at a rising edge. On accept, latch addr, wdata and wmask, and compute range.
  - In range: req_addr >= BASE_ADDR and req_addr < BASE_ADDR + 4*DEPTH (compare with 33-bit arithmetic, no wrap).
  - Word index: (req_addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
- Transitions:
  - WAIT=0: IDLE -> RESP on accept.
  - WAIT>0: IDLE -> WAITS on accept, with counter loaded to WAIT-1. WAITS decrements each cycle and moves to RESP on the edge where counter==0.
  - Accept-to-resp_valid latency: exactly 1+WAIT cycles.
- Access commit happens on the edge entering RESP:
  - resp_rdata <= RAM[index] (old value).
  - For each set wmask bit i, RAM[index][8i+7:8i] <= wdata[8i+7:8i].
  - Out of range: no RAM write, resp_rdata <= 0, resp_err <= 1. Otherwise resp_err <= 0.
- RESP holds resp_valid, resp_rdata and resp_err stable until resp_valid & resp_ready. On that edge go to IDLE and clear resp_valid; resp_rdata and resp_err keep their last values.
- Throughput: at most one request every 2+WAIT cycles. No request is accepted in the same cycle a response completes.
- req_valid deasserting while not ready has no effect. Inputs are sampled only at accept; later changes to req_* are ignored.
- resp_ready asserted outside RESP is ignored.
- Reset mid-operation, in WAITS or RESP: the pending request is dropped. If reset arrives before the commit edge, no RAM write occurs. Outputs return to reset values immediately (asynchronous).
- wmask 4'b0000 in range: pure read, resp_err=0. wmask any value out of range: resp_err=1 and nothing written.
- Back-to-back requests to the same word: the second read returns data including the first write.

Test Plan:
- WAIT=0: write addr 0x8, wdata 0xDEADBEEF, mask 4'b1111 -> resp_valid 1 cycle after accept, rdata=old word. Then read 0x8 -> rdata 0xDEADBEEF, err=0.
- Byte lanes: word 0x10 holds 0x11223344; write 0x00AA0000 with mask 4'b0100; then read 0x10 -> 0x11AA3344.
- WAIT=3: read accepted at cycle t -> resp_valid first high at t+4, req_ready low during t+1..t+4.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable. req_valid=1 throughout is not accepted until the cycle after the response handshake.
- Range: BASE_ADDR=0x100, DEPTH=64, write to 0x200 (first byte past the end) and to 0xFC -> err=1, rdata=0, and RAM is unchanged by full-dump compare.
- Reset: assert resetn=0 during WAITS (WAIT=2) of a write to 0x20 -> resp_valid=0 and req_ready=1 immediately. Read of 0x20 after release returns the pre-write value.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data-memory port.
// Accepts one load/store at a time, waits WAIT extra cycles, then commits the
// access to a word-organised RAM and presents the pre-write word and an
// out-of-range flag until the core takes the response.
//
// Ports:
//   clk, resetn            clock (rising edge), async active-low reset
//   req_valid / req_ready  request handshake
//   req_addr               byte address (bits [1:0] ignored)
//   req_wdata, req_wmask   lane-aligned store data and byte enables (0 = load)
//   resp_valid/resp_ready  response handshake
//   resp_rdata, resp_err   pre-write word read, out-of-range flag
module dmem_responder #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned WAIT      = 0,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam logic [3:0]  WaitLoad = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic [32:0] Span     = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {StIdle, StWaits, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wmask_q;
  logic              oor_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              commit;
  logic [32:0]       off;
  logic              in_range;
  logic [IdxW-1:0]   in_idx;
  logic [IdxW-1:0]   c_idx;
  logic [31:0]       c_wdata;
  logic [3:0]        c_wmask;
  logic              c_oor;

  // 33-bit offset: an address below BASE_ADDR goes negative (bit 32 set), so a
  // single unsigned compare against the span covers both bounds without wrap.
  assign off      = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign in_range = off < Span;
  assign in_idx   = off[IdxW+1:2];

  assign accept = req_valid && (state_q == StIdle);

  // With no wait states the commit edge is the accept edge, so the access
  // operands come straight from the request rather than the latched copy.
  assign c_idx   = (WAIT == 0) ? in_idx    : idx_q;
  assign c_wdata = (WAIT == 0) ? req_wdata : wdata_q;
  assign c_wmask = (WAIT == 0) ? req_wmask : wmask_q;
  assign c_oor   = (WAIT == 0) ? !in_range : oor_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWaits;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWaits: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      oor_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= in_idx;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        oor_q   <= !in_range;
      end
      if (commit) begin
        rdata_q <= c_oor ? 32'd0 : mem[c_idx];
        err_q   <= c_oor;
      end
    end
  end

  // RAM is not reset; a reset before the commit edge forces StIdle, so a
  // dropped request can never reach this write.
  always_ff @(posedge clk) begin
    if (commit && !c_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (c_wmask[i]) begin
          mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT=0/base 0, WAIT=3/base 0x100,
// WAIT=2/base 0) checked against a reference word memory through a scoreboard.
module tb_dmem_responder;

  localparam int unsigned PWait [3] = '{0, 3, 2};
  localparam logic [31:0] PBase [3] = '{32'h0, 32'h100, 32'h0};

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    bit          chk;
  } exp_t;

  logic        clk;
  logic [2:0]  resetn, req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_wmask [3];
  logic [31:0] resp_rdata [3];

  logic [31:0] ref_mem [3][64];
  exp_t        sb_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] nx_addr, nx_wdata;
  logic [3:0]  nx_wmask;

  dmem_responder #(.DEPTH(64), .WAIT(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .resetn(resetn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0])
  );
  dmem_responder #(.DEPTH(64), .WAIT(3), .BASE_ADDR(32'h100)) u_dut1 (
    .clk(clk), .resetn(resetn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1])
  );
  dmem_responder #(.DEPTH(64), .WAIT(2), .BASE_ADDR(32'h0)) u_dut2 (
    .clk(clk), .resetn(resetn[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_wmask(req_wmask[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int k, input int i);
    return {8'(k + 1), 8'(i), ~8'(i), 8'h5A};
  endfunction

  // Response monitor: pops one expectation per handshake, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    #2;
    for (int k = 0; k < 3; k++) begin
      if (resp_valid[k] && resp_ready[k]) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("resp_dut", 32'(k), 32'(e.dut));
          if (e.chk) check("resp_rdata", resp_rdata[k], e.rdata);
          check("resp_err", 32'(resp_err[k]), 32'(e.err));
        end
      end
    end
  end

  // One full transaction on dut k; called and returns at a falling edge.
  task automatic xact(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wmask, input int hold, input bit chk_rd,
                      input bit keep);
    exp_t        e;
    logic [32:0] off;
    bit          inr;
    int          idx;
    int          t;
    t = 0;
    while (!req_ready[k]) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        $display("FAIL ready_timeout dut=%0d got busy want ready", k);
        $fatal(1, "ready timeout");
      end
    end
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wmask[k] = wmask;
    req_valid[k] = 1'b1;
    off   = {1'b0, addr} - {1'b0, PBase[k]};
    inr   = off < 33'd256;
    idx   = int'(off[7:2]);
    e.dut = k;
    e.chk = chk_rd;
    e.err = !inr;
    e.rdata = inr ? ref_mem[k][idx] : 32'd0;
    sb_q.push_back(e);
    if (inr) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) ref_mem[k][idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    for (int n = 1; n <= int'(PWait[k]) + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (keep) begin
          req_addr[k]  = nx_addr;
          req_wdata[k] = nx_wdata;
          req_wmask[k] = nx_wmask;
        end else begin
          req_valid[k] = 1'b0;
          req_addr[k]  = ~addr;
          req_wdata[k] = ~wdata;
          req_wmask[k] = ~wmask;
        end
      end
      check("req_ready_busy", 32'(req_ready[k]), 32'd0);
      check("resp_valid_lat", 32'(resp_valid[k]), 32'(n == int'(PWait[k]) + 1));
      // resp_ready high during wait states must be ignored
      resp_ready[k] = (n <= int'(PWait[k]));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid[k]), 32'd1);
      check("hold_ready", 32'(req_ready[k]), 32'd0);
      if (chk_rd) check("hold_rdata", resp_rdata[k], e.rdata);
    end
    resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready[k] = 1'b0;
    check("resp_valid_done", 32'(resp_valid[k]), 32'd0);
    check("req_ready_idle", 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 3'b000;
    req_valid  = 3'b000;
    resp_ready = 3'b000;
    for (int k = 0; k < 3; k++) begin
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
      req_wmask[k] = 4'd0;
    end
    nx_addr  = 32'd0;
    nx_wdata = 32'd0;
    nx_wmask = 4'd0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_req_ready", 32'(req_ready[k]), 32'd1);
      check("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
      check("rst_rdata", resp_rdata[k], 32'd0);
      check("rst_err", 32'(resp_err[k]), 32'd0);
    end
    resetn = 3'b111;
    @(negedge clk);

    // Fill every RAM with a known pattern; old contents are unknown.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) begin
        xact(k, PBase[k] + 32'(4 * i), pat(k, i), 4'hF, 0, 1'b0, 1'b0);
      end
    end

    // WAIT=0 write then read back
    xact(0, 32'h8, 32'hDEADBEEF, 4'hF, 0, 1'b1, 1'b0);
    xact(0, 32'h8, 32'h0, 4'h0, 0, 1'b1, 1'b0);
    // Byte lanes, low address bits ignored
    xact(0, 32'h10, 32'h11223344, 4'hF, 0, 1'b1, 1'b0);
    xact(0, 32'h12, 32'h00AA0000, 4'b0100, 0, 1'b1, 1'b0);
    xact(0, 32'h10, 32'h0, 4'h0, 0, 1'b1, 1'b0);
    // Backpressure with the next request held valid throughout
    nx_addr  = 32'h10;
    nx_wdata = 32'h0;
    nx_wmask = 4'h0;
    xact(0, 32'h8, 32'h01020304, 4'hF, 5, 1'b1, 1'b1);
    xact(0, 32'h10, 32'h0, 4'h0, 0, 1'b1, 1'b0);
    xact(0, 32'h8, 32'h0, 4'h0, 0, 1'b1, 1'b0);

    // WAIT=3, base 0x100: latency, backpressure and range
    xact(1, 32'h104, 32'h0, 4'h0, 0, 1'b1, 1'b0);
    xact(1, 32'h1FC, 32'hA1B2C3D4, 4'b0011, 2, 1'b1, 1'b0);
    xact(1, 32'h200, 32'h12345678, 4'hF, 0, 1'b1, 1'b0);
    xact(1, 32'hFC, 32'h12345678, 4'hF, 0, 1'b1, 1'b0);
    xact(1, 32'hFFFF_FFFC, 32'h0, 4'h0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      xact(1, 32'h100 + 32'(4 * i), 32'h0, 4'h0, 0, 1'b1, 1'b0);
    end

    // WAIT=2: reset during wait states drops the write
    xact(2, 32'h20, 32'h0, 4'h0, 0, 1'b1, 1'b0);
    req_addr[2]  = 32'h20;
    req_wdata[2] = 32'hCAFEF00D;
    req_wmask[2] = 4'hF;
    req_valid[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("rst_mid_busy", 32'(req_ready[2]), 32'd0);
    #1 resetn[2] = 1'b0;
    #1;
    check("rst_mid_valid", 32'(resp_valid[2]), 32'd0);
    check("rst_mid_ready", 32'(req_ready[2]), 32'd1);
    check("rst_mid_rdata", resp_rdata[2], 32'd0);
    check("rst_mid_err", 32'(resp_err[2]), 32'd0);
    repeat (2) @(negedge clk);
    resetn[2] = 1'b1;
    @(negedge clk);
    xact(2, 32'h20, 32'h0, 4'h0, 0, 1'b1, 1'b0);
    // Back-to-back same word
    xact(2, 32'h24, 32'h55AA55AA, 4'b1001, 0, 1'b1, 1'b0);
    xact(2, 32'h24, 32'h0, 4'h0, 0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
